mem_list_reader: RTL

- Sits directly downstream of the byte-addressed memory `mem`.
  - Drives `mem`'s address port.
  - Consumes its combinational 16-bit big-endian read data: {memory[a], memory[a+1]}.
- On `start`, reads a length-prefixed list of 16-bit words at `base_addr`: a count word, then `count` data words.
- Streams the data words to the next stage over a valid/ready interface.
- Used to fetch node-ID / neighbour lists for the sink and routing logic.

---
 rtl/mem_pkg.sv | 16 +
 rtl/out_stage.sv | 31 +++
 rtl/mem_list_reader.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory geometry and list-reader state encoding
package mem_pkg;

  localparam int MEM_DEPTH  = 1024;
  localparam int MEM_WIDTH  = 8;
  localparam int WORD_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_CNT,
    STREAM,
    ERR,
    FIN
  } state_t;

endpackage

// File: rtl/out_stage.sv
// rtl/out_stage.sv - one-entry valid/ready output register
module out_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             last
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (!valid || ready) begin
      // Slot is free: either refill it or drain it; a stalled word holds.
      valid <= load;
      last  <= load && load_last;
      if (load) begin
        data <= load_data;
      end
    end
  end

endmodule

// File: rtl/mem_list_reader.sv
// rtl/mem_list_reader.sv - reads a length-prefixed word list from mem and streams it
module mem_list_reader #(
  parameter int MEM_DEPTH  = mem_pkg::MEM_DEPTH,
  parameter int WORD_WIDTH = mem_pkg::WORD_WIDTH,
  parameter int MAX_CNT    = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] base_addr,
  output logic [WORD_WIDTH-1:0] address,
  input  logic [WORD_WIDTH-1:0] mem_data,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [WORD_WIDTH-1:0] count
);

  import mem_pkg::*;

  localparam int AW         = WORD_WIDTH + 2;
  localparam int WORD_BYTES = WORD_WIDTH / MEM_WIDTH;
  localparam logic [AW-1:0]         DEPTH_W = AW'(MEM_DEPTH);
  localparam logic [WORD_WIDTH-1:0] MAX_W   = WORD_WIDTH'(MAX_CNT);
  localparam logic [WORD_WIDTH-1:0] STEP    = WORD_WIDTH'(WORD_BYTES);
  localparam logic [WORD_WIDTH-1:0] ONE     = WORD_WIDTH'(1);

  state_t                state;
  logic [WORD_WIDTH-1:0] ptr;
  logic [WORD_WIDTH-1:0] remaining;
  logic [AW-1:0]         list_end;
  logic                  slot_free;
  logic                  load;

  // Two extra bits keep the end-of-list sum from wrapping past 64 KiB.
  assign list_end  = AW'(ptr) + AW'(WORD_BYTES) + AW'(mem_data) * AW'(WORD_BYTES);
  assign slot_free = !out_valid || out_ready;
  assign load      = (state == STREAM) && slot_free && (remaining != '0);

  out_stage #(
    .WIDTH (WORD_WIDTH)
  ) u_out_stage (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_data (mem_data),
    .load_last (remaining == ONE),
    .ready     (out_ready),
    .data      (out_data),
    .valid     (out_valid),
    .last      (out_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      address   <= '0;
      ptr       <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ptr     <= base_addr;
            address <= base_addr;
            busy    <= 1'b1;
            error   <= 1'b0;
            state   <= base_addr[0] ? ERR : RD_CNT;
          end
        end
        RD_CNT: begin
          count     <= mem_data;
          remaining <= mem_data;
          if (mem_data == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end else if (mem_data > MAX_W || list_end > DEPTH_W) begin
            state <= ERR;
          end else begin
            address <= ptr + STEP;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (load) begin
            remaining <= remaining - ONE;
            // Stop advancing on the final word so address stays inside memory.
            if (remaining != ONE) begin
              address <= address + STEP;
            end
          end
          if (out_valid && out_ready && out_last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end
        end
        ERR: begin
          error <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= FIN;
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
